// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for decode_stage.
interface decode_stage_if;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_imm;
  logic [4:0]  id_rd;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [3:0]  id_alu_op;
  logic [23:0] id_ctrl;

  modport master (
    output if_valid, if_instr, if_pc, id_ready,
    input  if_ready, id_valid, id_pc, id_imm, id_rd, id_rs1, id_rs2, id_alu_op, id_ctrl
  );

  modport slave (
    input  if_valid, if_instr, if_pc, id_ready,
    output if_ready, id_valid, id_pc, id_imm, id_rd, id_rs1, id_rs2, id_alu_op, id_ctrl
  );
endinterface

// File: rtl/decode_stage.sv
// Instruction decode stage: DEPTH-entry fetch FIFO, RV32I(+M) decoder on the
// FIFO head, and a registered valid/ready output to execute.
module decode_stage #(
  parameter int unsigned DEPTH = 2,
  parameter bit          RV32M = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  decode_stage_if.slave bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] WORD_ECALL  = 32'h0000_0073;
  localparam logic [31:0] WORD_EBREAK = 32'h0010_0073;
  localparam logic [31:0] WORD_MRET   = 32'h3020_0073;

  // Bit positions inside id_ctrl.
  localparam int unsigned C_REG_WRITE = 0;
  localparam int unsigned C_RS1_READ  = 1;
  localparam int unsigned C_RS2_READ  = 2;
  localparam int unsigned C_OP1_ZERO  = 3;
  localparam int unsigned C_OP1_PC    = 4;
  localparam int unsigned C_OP2_IMM   = 5;
  localparam int unsigned C_OP2_4     = 6;
  localparam int unsigned C_BRANCH    = 7;
  localparam int unsigned C_JAL       = 8;
  localparam int unsigned C_JALR      = 9;
  localparam int unsigned C_MEM_READ  = 10;
  localparam int unsigned C_MEM_WRITE = 11;
  localparam int unsigned C_CSR_READ  = 12;
  localparam int unsigned C_CSR_WRITE = 13;
  localparam int unsigned C_MUL       = 14;
  localparam int unsigned C_DIV       = 15;
  localparam int unsigned C_MRET      = 16;
  localparam int unsigned C_ECALL     = 17;
  localparam int unsigned C_EBREAK    = 18;
  localparam int unsigned C_ILL       = 19;
  localparam int unsigned C_F3        = 20;
  localparam int unsigned C_FENCE     = 23;

  logic [31:0]      fifo_instr [DEPTH];
  logic [31:0]      fifo_pc    [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic push;
  logic pop;
  logic load;
  logic fifo_nonempty;

  logic [31:0] head;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd_f;
  logic [4:0]  rs1_f;
  logic [23:0] dec_ctrl;
  logic [3:0]  dec_alu;
  logic [31:0] dec_imm;
  logic        dec_ill;

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;

  assign fifo_nonempty = (count != '0);
  assign bus.if_ready  = (count < CNT_W'(DEPTH));
  assign load          = ~bus.id_valid | bus.id_ready;
  assign push          = bus.if_valid & bus.if_ready & ~flush;
  assign pop           = fifo_nonempty & load;

  assign head   = fifo_instr[rd_ptr];
  assign opcode = head[6:0];
  assign rd_f   = head[11:7];
  assign f3     = head[14:12];
  assign rs1_f  = head[19:15];
  assign f7     = head[31:25];

  assign imm_i = {{20{head[31]}}, head[31:20]};
  assign imm_s = {{20{head[31]}}, head[31:25], head[11:7]};
  assign imm_b = {{19{head[31]}}, head[31], head[7], head[30:25], head[11:8], 1'b0};
  assign imm_u = {head[31:12], 12'b0};
  assign imm_j = {{11{head[31]}}, head[31], head[19:12], head[20], head[30:21], 1'b0};
  assign imm_z = {27'b0, head[19:15]};

  // Decoder for the FIFO head; illegal words keep only ill_instr set.
  always_comb begin
    dec_ctrl = '0;
    dec_alu  = '0;
    dec_imm  = '0;
    dec_ill  = 1'b0;

    if (head[1:0] != 2'b11) begin
      dec_ill = 1'b1;
    end else begin
      case (opcode)
        OPC_OP: begin
          dec_ctrl[C_REG_WRITE] = 1'b1;
          dec_ctrl[C_RS1_READ]  = 1'b1;
          dec_ctrl[C_RS2_READ]  = 1'b1;
          dec_alu               = {f7[5], f3};
          if (f7 == 7'h01) begin
            dec_ill           = ~RV32M;
            dec_ctrl[C_MUL]   = ~f3[2];
            dec_ctrl[C_DIV]   = f3[2];
          end else if (f7 == 7'h20) begin
            dec_ill = ~((f3 == 3'b000) || (f3 == 3'b101));
          end else if (f7 != 7'h00) begin
            dec_ill = 1'b1;
          end
        end
        OPC_OP_IMM: begin
          dec_ctrl[C_REG_WRITE] = 1'b1;
          dec_ctrl[C_RS1_READ]  = 1'b1;
          dec_ctrl[C_OP2_IMM]   = 1'b1;
          dec_imm               = imm_i;
          // Only shifts-right carry the func7 qualifier; ADDI etc. keep bit 30 as immediate.
          dec_alu               = {(f3 == 3'b101) ? f7[5] : 1'b0, f3};
          if (f3 == 3'b001) dec_ill = (f7 != 7'h00);
          if (f3 == 3'b101) dec_ill = (f7 != 7'h00) && (f7 != 7'h20);
        end
        OPC_LOAD: begin
          dec_ctrl[C_REG_WRITE] = 1'b1;
          dec_ctrl[C_RS1_READ]  = 1'b1;
          dec_ctrl[C_OP2_IMM]   = 1'b1;
          dec_ctrl[C_MEM_READ]  = 1'b1;
          dec_ctrl[C_F3 +: 3]   = f3;
          dec_imm               = imm_i;
          dec_ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
        OPC_STORE: begin
          dec_ctrl[C_RS1_READ]  = 1'b1;
          dec_ctrl[C_RS2_READ]  = 1'b1;
          dec_ctrl[C_OP2_IMM]   = 1'b1;
          dec_ctrl[C_MEM_WRITE] = 1'b1;
          dec_ctrl[C_F3 +: 3]   = f3;
          dec_imm               = imm_s;
          dec_ill               = (f3 >= 3'b011);
        end
        OPC_BRANCH: begin
          dec_ctrl[C_RS1_READ] = 1'b1;
          dec_ctrl[C_RS2_READ] = 1'b1;
          dec_ctrl[C_BRANCH]   = 1'b1;
          dec_ctrl[C_F3 +: 3]  = f3;
          dec_imm              = imm_b;
          dec_ill = (f3 == 3'b010) || (f3 == 3'b011);
        end
        OPC_LUI: begin
          dec_ctrl[C_REG_WRITE] = 1'b1;
          dec_ctrl[C_OP1_ZERO]  = 1'b1;
          dec_ctrl[C_OP2_IMM]   = 1'b1;
          dec_imm               = imm_u;
        end
        OPC_AUIPC: begin
          dec_ctrl[C_REG_WRITE] = 1'b1;
          dec_ctrl[C_OP1_PC]    = 1'b1;
          dec_ctrl[C_OP2_IMM]   = 1'b1;
          dec_imm               = imm_u;
        end
        OPC_JAL: begin
          dec_ctrl[C_REG_WRITE] = 1'b1;
          dec_ctrl[C_OP1_PC]    = 1'b1;
          dec_ctrl[C_OP2_4]     = 1'b1;
          dec_ctrl[C_JAL]       = 1'b1;
          dec_imm               = imm_j;
        end
        OPC_JALR: begin
          dec_ctrl[C_REG_WRITE] = 1'b1;
          dec_ctrl[C_RS1_READ]  = 1'b1;
          dec_ctrl[C_OP1_PC]    = 1'b1;
          dec_ctrl[C_OP2_4]     = 1'b1;
          dec_ctrl[C_JALR]      = 1'b1;
          dec_imm               = imm_i;
        end
        OPC_FENCE: begin
          dec_ctrl[C_FENCE] = 1'b1;
        end
        OPC_SYSTEM: begin
          if (f3 == 3'b000) begin
            if (head == WORD_ECALL)       dec_ctrl[C_ECALL]  = 1'b1;
            else if (head == WORD_EBREAK) dec_ctrl[C_EBREAK] = 1'b1;
            else if (head == WORD_MRET)   dec_ctrl[C_MRET]   = 1'b1;
            else                          dec_ill            = 1'b1;
          end else if (f3 == 3'b100) begin
            dec_ill = 1'b1;
          end else begin
            // CSRRW/CSRRWI with rd=0 skip the read; CSRRS/C with rs1=0 skip the write.
            dec_ctrl[C_REG_WRITE] = 1'b1;
            dec_ctrl[C_RS1_READ]  = ~f3[2];
            dec_ctrl[C_CSR_READ]  = (f3[1:0] != 2'b01) || (rd_f != 5'd0);
            dec_ctrl[C_CSR_WRITE] = (f3[1:0] == 2'b01) || (rs1_f != 5'd0);
            dec_ctrl[C_F3 +: 3]   = f3;
            dec_imm               = f3[2] ? imm_z : imm_i;
          end
        end
        default: dec_ill = 1'b1;
      endcase
    end

    if (dec_ill) begin
      dec_ctrl        = '0;
      dec_ctrl[C_ILL] = 1'b1;
      dec_alu         = '0;
    end
  end

  // FIFO storage; not reset, contents qualified by count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= bus.if_instr;
      fifo_pc[wr_ptr]    <= bus.if_pc;
    end
  end

  // Pointers, count and output register; flush outranks push, pop and load.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      bus.id_valid  <= 1'b0;
      bus.id_pc     <= '0;
      bus.id_imm    <= '0;
      bus.id_rd     <= '0;
      bus.id_rs1    <= '0;
      bus.id_rs2    <= '0;
      bus.id_alu_op <= '0;
      bus.id_ctrl   <= '0;
    end else if (flush) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      bus.id_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (load) begin
        bus.id_valid <= fifo_nonempty;
        if (fifo_nonempty) begin
          bus.id_pc     <= fifo_pc[rd_ptr];
          bus.id_imm    <= dec_imm;
          bus.id_rd     <= head[11:7];
          bus.id_rs1    <= head[19:15];
          bus.id_rs2    <= head[24:20];
          bus.id_alu_op <= dec_alu;
          bus.id_ctrl   <= dec_ctrl;
        end
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: two instances differing only in RV32M.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;

  int vectors     = 0;
  int miscompares = 0;

  decode_stage_if bus0 ();
  decode_stage_if bus1 ();

  assign bus0.if_valid = if_valid;
  assign bus0.if_instr = if_instr;
  assign bus0.if_pc    = if_pc;
  assign bus0.id_ready = id_ready;
  assign bus1.if_valid = if_valid;
  assign bus1.if_instr = if_instr;
  assign bus1.if_pc    = if_pc;
  assign bus1.id_ready = id_ready;

  decode_stage #(.DEPTH(2), .RV32M(1'b0)) u_m0 (.clk(clk), .rst(rst), .flush(flush), .bus(bus0));
  decode_stage #(.DEPTH(2), .RV32M(1'b1)) u_m1 (.clk(clk), .rst(rst), .flush(flush), .bus(bus1));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Push one word with the output free, leave it sitting in the output register.
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    if_valid = 1'b1; if_instr = instr; if_pc = pc;
    step();
    if_valid = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0; id_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    check("rst_valid",   bus1.id_valid, 32'd0);
    check("rst_ready",   bus1.if_ready, 32'd1);
    check("rst_pc",      bus1.id_pc,    32'd0);
    check("rst_ctrl",    bus1.id_ctrl,  32'd0);
    check("rst_m0_ctrl", bus0.id_ctrl,  32'd0);

    // ADD x3,x1,x2: valid one edge after the push edge
    if_valid = 1'b1; if_instr = 32'h0020_81B3; if_pc = 32'h100;
    step();
    if_valid = 1'b0;
    check("add_lat0", bus1.id_valid, 32'd0);
    step();
    check("add_valid", bus1.id_valid,  32'd1);
    check("add_pc",    bus1.id_pc,     32'h100);
    check("add_rd",    bus1.id_rd,     32'd3);
    check("add_rs1",   bus1.id_rs1,    32'd1);
    check("add_rs2",   bus1.id_rs2,    32'd2);
    check("add_alu",   bus1.id_alu_op, 32'd0);
    check("add_ctrl",  bus1.id_ctrl,   32'h000007);
    step();
    check("add_drain", bus1.id_valid,  32'd0);

    // DIV x3,x1,x2 with and without M
    issue(32'h0220_C1B3, 32'h104);
    check("div_m0_ctrl", bus0.id_ctrl,   32'h080000);
    check("div_m1_ctrl", bus1.id_ctrl,   32'h008007);
    check("div_m1_alu",  bus1.id_alu_op, 32'd4);

    issue(32'h4020_9093, 32'h108);
    check("slli_f7_ctrl", bus1.id_ctrl, 32'h080000);

    issue(32'h4010_D093, 32'h10C);
    check("srai_alu",  bus1.id_alu_op, 32'hD);
    check("srai_imm",  bus1.id_imm,    32'h0000_0401);
    check("srai_ctrl", bus1.id_ctrl,   32'h000023);

    issue(32'hFFC1_2283, 32'h110);
    check("lw_imm",  bus1.id_imm,  32'hFFFF_FFFC);
    check("lw_ctrl", bus1.id_ctrl, 32'h200423);
    check("lw_rd",   bus1.id_rd,   32'd5);

    issue(32'hFFC1_3283, 32'h114);
    check("ld_ill", bus1.id_ctrl, 32'h080000);

    issue(32'hFE20_9CE3, 32'h118);
    check("bne_imm",  bus1.id_imm,  32'hFFFF_FFF8);
    check("bne_ctrl", bus1.id_ctrl, 32'h100086);

    issue(32'h0FF0_000F, 32'h11C);
    check("fence_ctrl", bus1.id_ctrl, 32'h800000);

    issue(32'h0000_0073, 32'h120);
    check("ecall_ctrl", bus1.id_ctrl, 32'h020000);
    issue(32'h0010_0073, 32'h124);
    check("ebreak_ctrl", bus1.id_ctrl, 32'h040000);
    issue(32'h3020_0073, 32'h128);
    check("mret_ctrl", bus1.id_ctrl, 32'h010000);
    issue(32'h1050_0073, 32'h12C);
    check("wfi_ctrl", bus1.id_ctrl, 32'h080000);
    issue(32'h0020_81B2, 32'h130);
    check("low_bits_ill", bus1.id_ctrl, 32'h080000);
    step();

    // Back-to-back throughput with id_ready high
    for (int i = 0; i < 3; i++) begin
      if_valid = 1'b1; if_instr = 32'h0000_0013 | (32'(i + 10) << 7); if_pc = 32'h300 + 32'(4 * i);
      step();
      if (i > 0) check("tput_pc", bus1.id_pc, 32'h300 + 32'(4 * (i - 1)));
    end
    if_valid = 1'b0;
    step();
    check("tput_last_pc", bus1.id_pc, 32'h308);
    check("tput_last_rd", bus1.id_rd, 32'd12);
    step();
    check("tput_empty", bus1.id_valid, 32'd0);

    // Stall: 4 offered, 3 accepted, outputs frozen
    id_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if_valid = 1'b1; if_instr = 32'h0000_0013 | (32'(i + 1) << 7); if_pc = 32'h200 + 32'(4 * i);
      check("stall_ifready", bus1.if_ready, (i < 3) ? 32'd1 : 32'd0);
      step();
    end
    check("stall_full", bus1.if_ready, 32'd0);
    check("stall_pc",   bus1.id_pc,    32'h200);
    step();
    check("stall_hold_pc", bus1.id_pc,    32'h200);
    check("stall_hold_rd", bus1.id_rd,    32'd1);
    check("stall_hold_v",  bus1.id_valid, 32'd1);
    if_valid = 1'b0; id_ready = 1'b1;
    step();
    check("drain1_pc", bus1.id_pc, 32'h204);
    check("drain1_rd", bus1.id_rd, 32'd2);
    step();
    check("drain2_pc", bus1.id_pc, 32'h208);
    check("drain2_v",  bus1.id_valid, 32'd1);
    step();
    check("drain_end", bus1.id_valid, 32'd0);

    // Flush with a full FIFO and a word offered in the same cycle
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if_valid = 1'b1; if_instr = 32'h0000_0013 | (32'(i + 20) << 7); if_pc = 32'h500 + 32'(4 * i);
      step();
    end
    check("flush_pre_full", bus1.if_ready, 32'd0);
    flush = 1'b1; if_valid = 1'b1; if_instr = 32'h0000_0F93; if_pc = 32'h5F0;
    step();
    flush = 1'b0; if_valid = 1'b0;
    check("flush_valid", bus1.id_valid, 32'd0);
    check("flush_ready", bus1.if_ready, 32'd1);
    id_ready = 1'b1;
    step();
    check("flush_empty1", bus1.id_valid, 32'd0);
    step();
    check("flush_empty2", bus1.id_valid, 32'd0);
    issue(32'h0000_0393, 32'h600);
    check("post_flush_pc", bus1.id_pc, 32'h600);
    check("post_flush_rd", bus1.id_rd, 32'd7);

    // Reset mid-stream zeroes everything
    id_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if_valid = 1'b1; if_instr = 32'h0000_0013 | (32'(i + 4) << 7); if_pc = 32'h700 + 32'(4 * i);
      step();
    end
    if_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_valid", bus1.id_valid, 32'd0);
    check("mrst_pc",    bus1.id_pc,    32'd0);
    check("mrst_ctrl",  bus1.id_ctrl,  32'd0);
    check("mrst_ready", bus1.if_ready, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
